// File: rtl/seq_div6_by3_if.sv
// Handshake and operand/result bundle for the 6-by-3 sequential divider.
// The controller side uses master and the divider uses slave.
interface seq_div6_by3_if;
   logic       start;
   logic [5:0] dividend;
   logic [2:0] divisor;
   logic       busy;
   logic       done;
   logic [5:0] quotient;
   logic [2:0] remainder;
   logic       div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_div6_by3.sv
// Sequential unsigned restoring divider: 6-bit dividend / 3-bit divisor.
// It produces one quotient bit per clock and uses a start/done handshake.
// All outputs are registered. Results hold until the next completed divide.
module seq_div6_by3 (
   input  logic          clk,
   input  logic          rst_n,
   seq_div6_by3_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state, state_nxt;
   logic [5:0] dq, dq_nxt;          // dividend shifting out, quotient shifting in
   logic [2:0] dv, dv_nxt;          // captured divisor
   logic [2:0] pr, pr_nxt;          // partial remainder, always < dv
   logic [2:0] cnt, cnt_nxt;        // iteration index 0..5
   logic       zero_pend, zero_pend_nxt;

   logic       busy_r, busy_nxt;
   logic       done_r, done_nxt;
   logic       dbz_r, dbz_nxt;
   logic [5:0] quo_r, quo_nxt;
   logic [2:0] rem_r, rem_nxt;

   // One restoring step. The 4-bit trial is wide enough for the compare.
   // When the subtraction is taken, the difference is below dv, so 3 bits hold it.
   logic [3:0] trial;
   logic       take;
   logic [2:0] pr_step;
   logic [5:0] dq_step;

   assign trial   = {pr, dq[5]};
   assign take    = (trial >= {1'b0, dv});
   assign pr_step = take ? (trial[2:0] - dv) : trial[2:0];
   assign dq_step = {dq[4:0], take};

   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.quotient    = quo_r;
   assign bus.remainder   = rem_r;
   assign bus.div_by_zero = dbz_r;

   // Next-state, datapath and registered-output values for the coming edge
   always_comb begin
      // NOTE: every variable gets a default first so that no path leaves one unassigned and infers a latch.
      state_nxt     = state;
      dq_nxt        = dq;
      dv_nxt        = dv;
      pr_nxt        = pr;
      cnt_nxt       = cnt;
      zero_pend_nxt = zero_pend;
      busy_nxt      = 1'b0;
      done_nxt      = 1'b0;
      quo_nxt       = quo_r;
      rem_nxt       = rem_r;
      dbz_nxt       = dbz_r;

      case (state)
         IDLE: begin
            if (zero_pend) begin
               // A zero-divisor request spends its capture cycle here. This puts done
               // one edge after acceptance. New starts are not taken in this cycle.
               zero_pend_nxt = 1'b0;
               state_nxt     = DONE;
               done_nxt      = 1'b1;
               quo_nxt       = 6'h3F;
               rem_nxt       = 3'd0;
               dbz_nxt       = 1'b1;
            end else if (bus.start) begin
               dq_nxt  = bus.dividend;
               dv_nxt  = bus.divisor;
               pr_nxt  = 3'd0;
               cnt_nxt = 3'd0;
               if (bus.divisor == 3'd0) begin
                  zero_pend_nxt = 1'b1;
               end else begin
                  state_nxt = CALC;
                  busy_nxt  = 1'b1;
               end
            end
         end

         CALC: begin
            pr_nxt  = pr_step;
            dq_nxt  = dq_step;
            cnt_nxt = cnt + 3'd1;
            if (cnt == 3'd5) begin
               state_nxt = DONE;
               done_nxt  = 1'b1;
               quo_nxt   = dq_step;
               rem_nxt   = pr_step;
               dbz_nxt   = 1'b0;
            end else begin
               busy_nxt = 1'b1;
            end
         end

         DONE: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, datapath and output registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         dq        <= 6'd0;
         dv        <= 3'd0;
         pr        <= 3'd0;
         cnt       <= 3'd0;
         zero_pend <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         quo_r     <= 6'd0;
         rem_r     <= 3'd0;
         dbz_r     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples pre-edge values.
         state     <= state_nxt;
         dq        <= dq_nxt;
         dv        <= dv_nxt;
         pr        <= pr_nxt;
         cnt       <= cnt_nxt;
         zero_pend <= zero_pend_nxt;
         busy_r    <= busy_nxt;
         done_r    <= done_nxt;
         quo_r     <= quo_nxt;
         rem_r     <= rem_nxt;
         dbz_r     <= dbz_nxt;
      end
   end

endmodule
